// File: rtl/bch_encoder_serial.sv
// Systematic bit-serial BCH encoder: message bits pass straight through, then PAR_W parity bits from an LFSR.
// Optional abort input enabled by defining BCH_ENC_ABORT_EN.
module bch_encoder_serial #(
  parameter int              MSG_LEN  = 4096,
  parameter int              PAR_W    = 208,
  parameter logic [PAR_W-1:0] GEN_POLY = '1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef BCH_ENC_ABORT_EN
  input  logic abort,
`endif
  input  logic s_valid,
  output logic s_ready,
  input  logic s_data,
  output logic m_valid,
  input  logic m_ready,
  output logic m_data,
  output logic m_par,
  output logic m_last
);

  localparam logic [0:0] MSG = 1'b0;
  localparam logic [0:0] PAR = 1'b1;
  localparam int MCW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int PCW = (PAR_W > 1) ? $clog2(PAR_W) : 1;

  logic [0:0]       state;
  logic [PAR_W-1:0] lfsr;
  logic [MCW-1:0]   mcnt;
  logic [PCW-1:0]   pcnt;
  logic             in_par, kill, msg_hs, par_hs, fb, par_end;

`ifdef BCH_ENC_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign in_par  = (state == PAR);
  assign par_end = (pcnt == PCW'(PAR_W-1));
  assign fb      = s_data ^ lfsr[PAR_W-1];
  assign msg_hs  = !in_par && s_valid && m_ready;
  assign par_hs  = in_par && m_ready;

  // Message phase is a zero-latency pass-through; parity phase drives from the LFSR MSB.
  always_comb begin
    m_valid = in_par ? 1'b1 : s_valid;
    s_ready = in_par ? 1'b0 : m_ready;
    m_data  = in_par ? lfsr[PAR_W-1] : s_data;
    m_par   = in_par;
    m_last  = in_par && par_end;
    if (kill) begin
      m_valid = 1'b0;
      s_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MSG;
      lfsr  <= '0;
      mcnt  <= '0;
      pcnt  <= '0;
    end else if (kill) begin
      state <= MSG;
      lfsr  <= '0;
      mcnt  <= '0;
      pcnt  <= '0;
    end else if (msg_hs) begin
      lfsr <= {lfsr[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
      if (mcnt == MCW'(MSG_LEN-1)) begin
        mcnt  <= '0;
        state <= PAR;
      end else begin
        mcnt <= mcnt + 1'b1;
      end
    end else if (par_hs) begin
      // Final parity bit returns straight to MSG so the next message bit follows with no bubble.
      if (par_end) begin
        state <= MSG;
        pcnt  <= '0;
        lfsr  <= '0;
      end else begin
        lfsr <= {lfsr[PAR_W-2:0], 1'b0};
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule
